// File: rtl/module_restoring_divider_if.sv
// Start/done handshake and operand/result bundle for the restoring divider.
// The controlling FSM or bench owns the master side; the divider is the slave.
interface module_restoring_divider_if #(
    parameter int DIV_WIDTH = 16
);
    logic                 start_i;
    logic [DIV_WIDTH-1:0] dividend_i;
    logic [DIV_WIDTH-1:0] divisor_i;
    logic                 busy_o;
    logic                 done_o;
    logic [DIV_WIDTH-1:0] quotient_o;
    logic [DIV_WIDTH-1:0] remainder_o;
    logic                 div_by_zero_o;

    modport master (
        output start_i, dividend_i, divisor_i,
        input  busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
    );

    modport slave (
        input  start_i, dividend_i, divisor_i,
        output busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
    );
endinterface

// File: rtl/module_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, results
// held in output registers until the next completion.
module module_restoring_divider #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    module_restoring_divider_if.slave  bus
);
    localparam int                CNT_W     = $clog2(DIV_WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] rem_q;
    logic [DIV_WIDTH-1:0] dvd_q;
    logic [DIV_WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 dbz_q;
    logic [DIV_WIDTH-1:0] quot_q;
    logic [DIV_WIDTH-1:0] rmd_q;
    logic                 dbz_out_q;

    logic [DIV_WIDTH:0]   shifted;
    logic [DIV_WIDTH:0]   trial;
    logic [DIV_WIDTH-1:0] rem_next;
    logic [DIV_WIDTH-1:0] dvd_next;
    logic                 last_iter;

    // The restored partial remainder is always below the divisor, so it fits
    // DIV_WIDTH bits; only the shifted value and the trial need the extra bit.
    assign shifted   = {rem_q, dvd_q[DIV_WIDTH-1]};
    assign trial     = shifted - {1'b0, dvs_q};
    assign rem_next  = trial[DIV_WIDTH] ? shifted[DIV_WIDTH-1:0] : trial[DIV_WIDTH-1:0];
    assign dvd_next  = {dvd_q[DIV_WIDTH-2:0], ~trial[DIV_WIDTH]};
    assign last_iter = (cnt_q == LAST_ITER);

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start_i) state_d = CALC;
            CALC:    if (dbz_q || last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: these are plain flip-flops, not a memory array, so they all take
    // the asynchronous reset and an aborted division leaves nothing behind.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            dbz_q     <= 1'b0;
            quot_q    <= '0;
            rmd_q     <= '0;
            dbz_out_q <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.start_i) begin
                dvd_q <= bus.dividend_i;
                dvs_q <= bus.divisor_i;
                rem_q <= '0;
                cnt_q <= '0;
                dbz_q <= (bus.divisor_i == '0);
            end else if (state_q == CALC) begin
                // A zero divisor spends its single CALC cycle publishing the
                // saturated result instead of iterating.
                if (dbz_q) begin
                    quot_q    <= '1;
                    rmd_q     <= dvd_q;
                    dbz_out_q <= 1'b1;
                end else begin
                    rem_q <= rem_next;
                    dvd_q <= dvd_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        quot_q    <= dvd_next;
                        rmd_q     <= rem_next;
                        dbz_out_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.busy_o        = (state_q != IDLE);
    assign bus.done_o        = (state_q == DONE);
    assign bus.quotient_o    = quot_q;
    assign bus.remainder_o   = rmd_q;
    assign bus.div_by_zero_o = dbz_out_q;
endmodule

// File: tb/tb_module_restoring_divider.sv
// Directed and reference-checked bench for module_restoring_divider: latency,
// results, divide-by-zero, ignored starts and asynchronous abort.
module tb_module_restoring_divider;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    module_restoring_divider_if #(.DIV_WIDTH(W)) bus ();

    module_restoring_divider #(.DIV_WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Issues one start pulse and follows the division to completion and back
    // to idle. Returns on a falling edge with the divider idle.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                           input logic exp_dbz, input int exp_lat);
        int lat;
        int nbusy;
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        nbusy = bus.busy_o ? 1 : 0;
        lat   = 0;
        while (!bus.done_o && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (bus.busy_o) nbusy++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, nbusy, exp_lat + 1);
        check({tag, "_quot"}, bus.quotient_o, exp_q);
        check({tag, "_rem"}, bus.remainder_o, exp_r);
        check({tag, "_dbz"}, bus.div_by_zero_o, exp_dbz);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_drop"}, bus.done_o, 1'b0);
        check({tag, "_idle"}, bus.busy_o, 1'b0);
    endtask

    initial begin
        int lat;
        int ndone;
        logic [W-1:0] a;
        logic [W-1:0] b;

        bus.start_i    = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;

        // Reset state.
        #12;
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_quot", bus.quotient_o, 0);
        check("rst_rem", bus.remainder_o, 0);
        check("rst_dbz", bus.div_by_zero_o, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-computed results.
        run_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16);
        run_div("dffff_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'd0, 1'b0, 16);
        run_div("d5_9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 16);
        run_div("dffff_ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 16);
        run_div("d0_5", 16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 16);
        run_div("d1234_0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1);
        run_div("d10_3", 16'd10, 16'd3, 16'd3, 16'd1, 1'b0, 16);

        // start_i held high with operands changing during CALC: 1000/10 used,
        // previous 3 r1 stays visible until the new completion.
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.dividend_i = 16'd1000;
        bus.divisor_i  = 16'd10;
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus.dividend_i = 16'(k * 37 + 5);
            bus.divisor_i  = 16'(k + 2);
            if (k == 8) begin
                check("hold_quot_stable", bus.quotient_o, 3);
                check("hold_rem_stable", bus.remainder_o, 1);
            end
            @(posedge clk);
        end
        @(negedge clk);
        check("hold_done", bus.done_o, 1);
        check("hold_quot", bus.quotient_o, 100);
        check("hold_rem", bus.remainder_o, 0);
        bus.dividend_i = 16'd99;
        bus.divisor_i  = 16'd5;
        @(posedge clk);
        @(negedge clk);
        check("hold_no_accept_in_done", bus.busy_o, 0);
        bus.dividend_i = 16'd77;
        bus.divisor_i  = 16'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        check("hold_accept_busy", bus.busy_o, 1);
        lat = 0;
        while (!bus.done_o && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("hold2_lat", lat, 16);
        check("hold2_quot", bus.quotient_o, 11);
        check("hold2_rem", bus.remainder_o, 0);
        @(posedge clk);
        @(negedge clk);

        // Asynchronous reset during the eighth iteration discards the division.
        bus.start_i    = 1'b1;
        bus.dividend_i = 16'd5000;
        bus.divisor_i  = 16'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_busy", bus.busy_o, 0);
        check("abort_done", bus.done_o, 0);
        check("abort_quot", bus.quotient_o, 0);
        check("abort_rem", bus.remainder_o, 0);
        check("abort_dbz", bus.div_by_zero_o, 0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done_o) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_div("d200_10", 16'd200, 16'd10, 16'd20, 16'd0, 1'b0, 16);

        // Random operand pairs against the behavioural quotient/remainder.
        for (int k = 0; k < 50; k++) begin
            a = 16'($urandom);
            b = 16'($urandom_range(1, 16'hFFFF));
            if (k % 5 == 0) b = 16'($urandom_range(1, 40));
            run_div($sformatf("rnd%0d", k), a, b, a / b, a % b, 1'b0, 16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
